// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between instruction fetch and data access.
// Data has priority but alternates with fetch under contention; RAM ERROR
// responses are retried after a short idle gap and counted.
module mem_arbiter #(
    parameter int unsigned RETRY_GAP = 1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic [7:0]  errcnt
);

    localparam int unsigned CW = 3;
    localparam int unsigned EW = 8;

    localparam logic [1:0] RS_ACCESS = 2'b10;
    localparam logic [1:0] RS_ERROR  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        DATA  = 2'b01,
        INSTR = 2'b10,
        RETRY = 2'b11
    } state_e;

    state_e        state_q, state_d;
    logic          last_d_q, last_d_d;
    logic          owner_d_q, owner_d_d;
    logic [CW-1:0] retry_q, retry_d;
    logic [EW-1:0] errcnt_q, errcnt_d;

    logic dreq;
    logic is_access;
    logic is_error;
    logic owner_req;

    assign dreq      = dREN | dWEN;
    assign is_access = (ramstate == RS_ACCESS);
    assign is_error  = (ramstate == RS_ERROR);
    assign owner_req = owner_d_q ? dreq : iREN;
    assign errcnt    = errcnt_q;

    // Next-state: grant selection, completion, error retry and abort
    always_comb begin
        state_d   = state_q;
        last_d_d  = last_d_q;
        owner_d_d = owner_d_q;
        retry_d   = retry_q;
        errcnt_d  = errcnt_q;
        unique case (state_q)
            IDLE: begin
                if (dreq && (!iREN || !last_d_q)) begin
                    state_d = DATA;
                end else if (iREN) begin
                    state_d = INSTR;
                end
            end
            DATA: begin
                if (is_error && (errcnt_q != {EW{1'b1}})) begin
                    errcnt_d = errcnt_q + EW'(1);
                end
                if (!dreq) begin
                    state_d = IDLE;
                end else if (is_access) begin
                    state_d  = IDLE;
                    last_d_d = 1'b1;
                end else if (is_error) begin
                    state_d   = RETRY;
                    owner_d_d = 1'b1;
                    retry_d   = '0;
                end
            end
            INSTR: begin
                if (is_error && (errcnt_q != {EW{1'b1}})) begin
                    errcnt_d = errcnt_q + EW'(1);
                end
                if (!iREN) begin
                    state_d = IDLE;
                end else if (is_access) begin
                    state_d  = IDLE;
                    last_d_d = 1'b0;
                end else if (is_error) begin
                    state_d   = RETRY;
                    owner_d_d = 1'b0;
                    retry_d   = '0;
                end
            end
            RETRY: begin
                if (!owner_req) begin
                    state_d = IDLE;
                    retry_d = '0;
                end else if (retry_q == CW'(RETRY_GAP - 1)) begin
                    state_d = owner_d_q ? DATA : INSTR;
                    retry_d = '0;
                end else begin
                    retry_d = retry_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and bookkeeping registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            last_d_q  <= 1'b0;
            owner_d_q <= 1'b0;
            retry_q   <= '0;
            errcnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            last_d_q  <= last_d_d;
            owner_d_q <= owner_d_d;
            retry_q   <= retry_d;
            errcnt_q  <= errcnt_d;
        end
    end

    // RAM strobes and requester wait/load, decoded from the granted state
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        unique case (state_q)
            DATA: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = ~dWEN;
                if (dreq && is_access) begin
                    dwait = 1'b0;
                    dload = ramload;
                end
            end
            INSTR: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
                if (iREN && is_access) begin
                    iwait = 1'b0;
                    iload = ramload;
                end
            end
            default: ;
        endcase
    end

endmodule
